// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the two-digit BCD scan display.
// Segment codes are in {g,f,e,d,c,b,a} order, active-high.
package bcd_disp_pkg;
   typedef enum logic {IDLE = 1'b0, CONVERT = 1'b1} state_t;

   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam int DIGITS = 2;
endpackage

// File: rtl/bcd_scan_display_if.sv
// Adder-result capture handshake plus the multiplexed display bus.
interface bcd_scan_display_if;
   import bcd_disp_pkg::*;

   logic              load;
   logic [3:0]        sum;
   logic              cout;
   logic              ready;
   logic [6:0]        seg;
   logic [DIGITS-1:0] digit_en;

   modport master (output load, sum, cout, input ready, seg, digit_en);
   modport slave  (input load, sum, cout, output ready, seg, digit_en);
endinterface

// File: rtl/seg7_bcd_decode.sv
// Combinational BCD digit to 7-segment pattern; non-decimal codes go blank.
module seg7_bcd_decode
   import bcd_disp_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);
   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end
endmodule

// File: rtl/bcd_scan_display.sv
// Captures {cout,sum}, converts to two BCD digits by repeated subtract-by-ten,
// and scans both digits onto a shared segment bus. Option: LEAD_ZERO_BLANK_EN.
module bcd_scan_display
   import bcd_disp_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
)(
   input  logic              clk,
   input  logic              rst_n,
   bcd_scan_display_if.slave bus
);
   localparam int CNT_W = $clog2(REFRESH_DIV);

   state_t           state, state_nxt;
   logic [4:0]       rem;
   logic [1:0]       tcnt;
   logic [3:0]       ones_q;
   logic [1:0]       tens_q;
   logic [CNT_W-1:0] rcnt;
   logic             digit_sel;
   logic             ge10;
   logic [3:0]       digit_bcd;
   logic [6:0]       dec_seg;

   assign ge10 = (rem >= 5'd10);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.load) state_nxt = CONVERT;
         CONVERT: if (!ge10)    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.ready = (state == IDLE);
   end

   // Display registers only change on the final CONVERT edge, so the old value stays up until then.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem    <= '0;
         tcnt   <= '0;
         ones_q <= '0;
         tens_q <= '0;
      end else begin
         case (state)
            IDLE: if (bus.load) begin
               rem  <= {bus.cout, bus.sum};
               tcnt <= '0;
            end
            CONVERT: if (ge10) begin
               rem  <= rem - 5'd10;
               tcnt <= tcnt + 2'd1;
            end else begin
               ones_q <= rem[3:0];
               tens_q <= tcnt;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcnt      <= '0;
         digit_sel <= 1'b0;
      end else if (rcnt == CNT_W'(REFRESH_DIV - 1)) begin
         rcnt      <= '0;
         digit_sel <= ~digit_sel;
      end else begin
         rcnt <= rcnt + 1'b1;
      end
   end

   assign digit_bcd = digit_sel ? {2'b00, tens_q} : ones_q;

   seg7_bcd_decode u_dec (
      .bcd (digit_bcd),
      .seg (dec_seg)
   );

   always_comb begin
      bus.digit_en = digit_sel ? 2'b10 : 2'b01;
      bus.seg      = dec_seg;
`ifdef LEAD_ZERO_BLANK_EN
      if (digit_sel && (tens_q == 2'd0)) begin
         bus.digit_en = 2'b00;
         bus.seg      = SEG_BLANK;
      end
`endif
   end
endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomized self-checking bench for bcd_scan_display with REFRESH_DIV=4.
module tb_bcd_scan_display;
   localparam int RD = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   bcd_scan_display_if bus();

   bcd_scan_display #(.REFRESH_DIV(RD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: edges since reset release give the scan phase, disp is the shown value.
   int cyc;
   int disp;
   int npass = 0;
   int ntot  = 0;
   logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      ntot++;
      assert (got === exp) npass++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic chk_disp(input string tag);
      int sel;
      logic [6:0] es;
      logic [1:0] ee;
      sel = (cyc / RD) % 2;
      if (sel == 0) begin
         ee = 2'b01;
         es = seg_tab[disp % 10];
      end else begin
         ee = 2'b10;
         es = seg_tab[disp / 10];
`ifdef LEAD_ZERO_BLANK_EN
         if (disp / 10 == 0) begin
            ee = 2'b00;
            es = 7'h00;
         end
`endif
      end
      chk({tag, ".en"},  {6'd0, bus.digit_en}, {6'd0, ee});
      chk({tag, ".seg"}, {1'b0, bus.seg},      {1'b0, es});
   endtask

   task automatic scan(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         chk_disp("scan");
      end
   endtask

   // Conversion takes floor(v/10)+1 busy cycles; junk loads during CONVERT must be ignored.
   task automatic do_load(input int v, input bit junk);
      int t;
      t = v / 10;
      @(negedge clk);
      bus.load = 1'b1;
      {bus.cout, bus.sum} = 5'(v);
      @(posedge clk); #1;
      bus.load = 1'b0;
      chk("ready_lo", {7'd0, bus.ready}, 8'd0);
      chk_disp("hold");
      for (int i = 0; i < t; i++) begin
         if (junk) begin
            bus.load = 1'b1;
            {bus.cout, bus.sum} = 5'($urandom_range(0, 31));
         end
         @(posedge clk); #1;
         bus.load = 1'b0;
         chk("ready_lo", {7'd0, bus.ready}, 8'd0);
         chk_disp("hold");
      end
      @(posedge clk); #1;
      disp = v;
      chk("ready_hi", {7'd0, bus.ready}, 8'd1);
      chk_disp("commit");
   endtask

   initial begin
      bus.load = 1'b0;
      bus.sum  = 4'd0;
      bus.cout = 1'b0;
      disp     = 0;

      #12;
      chk("rst.seg",   {1'b0, bus.seg},      8'h3F);
      chk("rst.en",    {6'd0, bus.digit_en}, 8'h01);
      chk("rst.ready", {7'd0, bus.ready},    8'h01);
      @(negedge clk);
      rst_n = 1'b1;
      scan(9);

      do_load(25, 1'b0); scan(8);
      do_load(31, 1'b0); scan(8);
      do_load(9,  1'b0); scan(8);
      do_load(25, 1'b1); scan(4);
      do_load(4,  1'b0); scan(8);

      repeat (12) begin
         do_load(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
         scan(int'($urandom_range(0, 5)));
      end

      // Abort a v=31 conversion on its second CONVERT cycle.
      @(negedge clk);
      bus.load = 1'b1;
      {bus.cout, bus.sum} = 5'd31;
      @(posedge clk); #1;
      bus.load = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      disp = 0;
      chk("abort.seg",   {1'b0, bus.seg},      8'h3F);
      chk("abort.en",    {6'd0, bus.digit_en}, 8'h01);
      chk("abort.ready", {7'd0, bus.ready},    8'h01);
      @(negedge clk);
      rst_n = 1'b1;
      do_load(12, 1'b0);
      scan(8);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
